// File: rtl/decoder_pkg.sv
// Shared state encoding, widths and the code-to-one-hot mapping for decoder_2to4_pulse.
package decoder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int CNT_W = 8;
    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HOLD = ST_HOLD,
        S_GAP  = ST_GAP
    } state_e;

    function automatic logic [3:0] onehot2to4(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

endpackage

// File: rtl/decoder_2to4_pulse_pulse_timer.sv
// 8-bit loadable down-counter; stops at zero and flags it. Shared by the HOLD and GAP phases.
module pulse_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/decoder_2to4_pulse.sv
// Registered 2-to-4 one-hot decoder: accepts a code on valid&&ready, holds the one-hot
// line for HOLD cycles, then stays quiet for GAP cycles before accepting the next code.
module decoder_2to4_pulse
    import decoder_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_code,
    output logic             in_ready,
    output logic [3:0]       d,
    output logic             d_valid,
    output logic [CNT_W-1:0] dec_cnt
);

    generate
        if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
            $error("decoder_2to4_pulse: HOLD must be in 1..255");
        end
        if (GAP < 0 || GAP > 255) begin : g_bad_gap
            $error("decoder_2to4_pulse: GAP must be in 0..255");
        end
    endgenerate

    localparam logic [TMR_W-1:0] HOLD_M1 = TMR_W'(HOLD - 1);
    localparam logic [TMR_W-1:0] GAP_M1  = (GAP > 0) ? TMR_W'(GAP - 1) : '0;
    localparam bit               HAS_GAP = (GAP > 0);

    state_e           state, state_n;
    logic [3:0]       d_n;
    logic             d_valid_n;
    logic [CNT_W-1:0] dec_cnt_n;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;

    pulse_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            d       <= 4'b0000;
            d_valid <= 1'b0;
            dec_cnt <= '0;
        end else begin
            state   <= state_n;
            d       <= d_n;
            d_valid <= d_valid_n;
            dec_cnt <= dec_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        d_n       = d;
        d_valid_n = d_valid;
        dec_cnt_n = dec_cnt;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    d_n       = onehot2to4(in_code);
                    d_valid_n = 1'b1;
                    dec_cnt_n = dec_cnt + CNT_W'(1);
                    tmr_load  = 1'b1;
                    tmr_value = HOLD_M1;
                    state_n   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tmr_zero) begin
                    d_n       = 4'b0000;
                    d_valid_n = 1'b0;
                    if (HAS_GAP) begin
                        tmr_load  = 1'b1;
                        tmr_value = GAP_M1;
                        state_n   = S_GAP;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                d_n       = 4'b0000;
                d_valid_n = 1'b0;
                if (tmr_zero) begin
                    state_n = S_IDLE;
                end
            end
            // Unreachable encoding: drop any pulse and return to accepting codes.
            default: begin
                d_n       = 4'b0000;
                d_valid_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    // Handshake: a code transfers on a rising edge where in_valid && in_ready; the
    // source keeps in_code stable until then, and in_valid while not ready is dropped.
    assign in_ready = (state == S_IDLE);

endmodule

// File: tb/tb_decoder_2to4_pulse.sv
// Directed bench for decoder_2to4_pulse: one HOLD=4/GAP=1 instance and one HOLD=4/GAP=0 instance.
module tb_decoder_2to4_pulse;

    localparam int HOLD_A = 4;
    localparam int GAP_A  = 1;
    localparam int HOLD_B = 4;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;

    logic       in_valid = 1'b0;
    logic [1:0] in_code = 2'b00;
    logic       in_ready;
    logic [3:0] d;
    logic       d_valid;
    logic [7:0] dec_cnt;

    logic       in_valid_b = 1'b0;
    logic [1:0] in_code_b = 2'b01;
    logic       in_ready_b;
    logic [3:0] d_b;
    logic       d_valid_b;
    logic [7:0] dec_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    decoder_2to4_pulse #(.HOLD(HOLD_A), .GAP(GAP_A)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .d        (d),
        .d_valid  (d_valid),
        .dec_cnt  (dec_cnt)
    );

    decoder_2to4_pulse #(.HOLD(HOLD_B), .GAP(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid_b),
        .in_code  (in_code_b),
        .in_ready (in_ready_b),
        .d        (d_b),
        .d_valid  (d_valid_b),
        .dec_cnt  (dec_cnt_b)
    );

    // clock / reset
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the first negedge after the transfer edge.
    task automatic send(input logic [1:0] code);
        int waited = 0;
        in_valid = 1'b1;
        in_code  = code;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("send_ready_timeout", (waited < 100), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [3:0] hold_val(input logic [1:0] code, input int c);
        return (c >= 1 && c <= HOLD_A) ? (4'b0001 << code) : 4'b0000;
    endfunction

    initial begin
        // Reset with the clock stopped: every output must settle immediately.
        #2 rst = 1'b1;
        #1;
        check_eq("rst_d", d, 4'b0000);
        check_eq("rst_d_valid", d_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_dec_cnt", dec_cnt, 0);
        check_eq("rst_b_in_ready", in_ready_b, 1);
        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single code 10 with HOLD=4, GAP=1.
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 2'b10;
        check_eq("single_ready_c0", in_ready, 1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq($sformatf("single_d_c%0d", c), d, hold_val(2'b10, c));
            check_eq($sformatf("single_dv_c%0d", c), d_valid, (c <= HOLD_A));
            check_eq($sformatf("single_ready_c%0d", c), in_ready, (c >= HOLD_A + GAP_A + 1));
        end
        check_eq("single_dec_cnt", dec_cnt, 1);

        // Back-to-back stream of all four codes.
        pulse_reset();
        exp_q.delete();
        obs_q.delete();
        exp_q.push_back(4'b0000);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < HOLD_A; j++) exp_q.push_back(4'b0001 << k);
            exp_q.push_back(4'b0000);
            exp_q.push_back(4'b0000);
        end
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 4; k++) send(2'(k));
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    obs_q.push_back(d);
                    @(negedge clk);
                end
            end
        join
        check_eq("stream_len", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq($sformatf("stream_d_%0d", i), obs_q[i], exp_q[i]);
        check_eq("stream_dec_cnt", dec_cnt, 4);

        // A one-cycle in_valid during HOLD is ignored, not queued.
        pulse_reset();
        @(negedge clk);
        send(2'b01);
        in_valid = 1'b1;
        in_code  = 2'b11;
        check_eq("ignore_d_c1", d, 4'b0010);
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq($sformatf("ignore_d_c%0d", c), d, hold_val(2'b01, c));
            check_eq($sformatf("ignore_cnt_c%0d", c), dec_cnt, 1);
        end

        // Asynchronous reset on cycle 2 of a 0010 pulse.
        pulse_reset();
        @(negedge clk);
        send(2'b01);
        @(negedge clk);
        check_eq("midrst_before_d", d, 4'b0010);
        rst = 1'b1;
        #1;
        check_eq("midrst_d", d, 4'b0000);
        check_eq("midrst_dv", d_valid, 0);
        check_eq("midrst_ready", in_ready, 1);
        check_eq("midrst_cnt", dec_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(2'b11);
        check_eq("midrst_next_d", d, 4'b1000);
        check_eq("midrst_next_dv", d_valid, 1);
        check_eq("midrst_next_cnt", dec_cnt, 1);

        // GAP=0 instance: 256 transfers with in_valid held high.
        begin
            int rises = 0;
            int last_rise = 0;
            int bad_spacing = 0;
            int bad_shape = 0;
            int dv_cycles = 0;
            logic prev_dv = 1'b0;
            @(negedge clk);
            in_valid_b = 1'b1;
            for (int cyc = 0; cyc < 3000 && rises < 256; cyc++) begin
                @(negedge clk);
                if (d_valid_b) dv_cycles++;
                if (!d_valid_b && d_b != 4'b0000) bad_shape++;
                if (d_valid_b && d_b != 4'b0010) bad_shape++;
                if (d_valid_b && !prev_dv) begin
                    rises++;
                    if (rises > 1 && (cyc - last_rise) != HOLD_B + 1) bad_spacing++;
                    last_rise = cyc;
                    if (rises == 1) check_eq("wrap_cnt_first", dec_cnt_b, 1);
                    if (rises == 255) check_eq("wrap_cnt_255", dec_cnt_b, 255);
                    if (rises == 256) check_eq("wrap_cnt_256", dec_cnt_b, 0);
                end
                prev_dv = d_valid_b;
            end
            in_valid_b = 1'b0;
            check_eq("wrap_rises", rises, 256);
            check_eq("wrap_spacing_errors", bad_spacing, 0);
            check_eq("wrap_shape_errors", bad_shape, 0);
            check_eq("wrap_dv_cycles", dv_cycles, 255 * HOLD_B + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
